// File: rtl/fb_arb_pkg.sv
// ----------------------------------------------------------------------------
// fb_arb_pkg
// Shared types and constants for the framebuffer port arbiter.
//   arb_state_e : fill-engine FSM states (IDLE, DRAIN, CLEAR)
//   grant_e     : owner of the RAM slot in a given cycle
//   fb_pixels() : number of addressable pixels for a given geometry
// ----------------------------------------------------------------------------
package fb_arb_pkg;

    localparam int unsigned FB_W_DEFAULT = 32'd320;
    localparam int unsigned FB_H_DEFAULT = 32'd240;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        G_IDLE  = 2'd0,
        G_READ  = 2'd1,
        G_CLEAR = 2'd2,
        G_WRITE = 2'd3
    } grant_e;

    function automatic int unsigned fb_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    localparam int unsigned FB_PIXELS = fb_pixels(FB_W_DEFAULT, FB_H_DEFAULT);

endpackage

// File: rtl/fb_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// fb_port_arbiter_if
// Bundles the scanout read port, pixel write port, clear-engine controls,
// queue status and the single-port RAM bus of the framebuffer arbiter.
//   master : requesters + RAM (drives rd_*, wr_*, clr_start/color, mem_rdata)
//   slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface fb_port_arbiter_if #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic [LVL_W-1:0]  fifo_level;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
        input  rd_data, rd_valid, wr_ready, clr_busy, clr_done, fifo_level,
               mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
        output rd_data, rd_valid, wr_ready, clr_busy, clr_done, fifo_level,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// ----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous FIFO holding pending {addr,data} pixel writes.
//   i_clk, i_rst        : clock, synchronous active-high reset (empties queue)
//   i_push, i_push_data : enqueue (ignored while full)
//   i_pop, o_pop_data   : dequeue; o_pop_data shows the head entry
//   o_full, o_empty     : occupancy flags
//   o_level             : number of stored entries
// ----------------------------------------------------------------------------
module fb_wr_fifo
    import fb_arb_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_level == LVL_W'(DEPTH));
    assign o_empty    = (r_level == LVL_W'(0));
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of 2 so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_level  <= LVL_W'(0);
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// ----------------------------------------------------------------------------
// fb_port_arbiter
// Shares one single-port framebuffer RAM between VGA scanout reads (absolute
// priority), a queued pixel writer and a full-screen clear engine.
//   clk_clk     : system clock
//   reset_reset : synchronous active-high reset
//   bus         : rd_* scanout port, wr_* write port, clr_* fill control,
//                 fifo_level status and registered mem_* RAM port
// ----------------------------------------------------------------------------
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned FB_W       = 320,
    parameter int unsigned FB_H       = 240,
    parameter int          ADDR_W     = 17,
    parameter int          DATA_W     = 12,
    parameter int          FIFO_DEPTH = 4
) (
    input logic              clk_clk,
    input logic              reset_reset,
    fb_port_arbiter_if.slave bus
);
    localparam int          LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PIXELS = fb_pixels(FB_W, FB_H);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_CLEAR = CLEAR;

    logic [1:0]               r_state;
    logic [ADDR_W-1:0]        r_clr_cnt;
    logic [DATA_W-1:0]        r_clr_color;
    logic                     r_clr_busy;
    logic                     r_clr_done;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [DATA_W-1:0]        r_mem_wdata;
    logic                     r_mem_we;
    logic [1:0]               r_rd_pipe;

    grant_e                   w_grant;
    logic                     w_wr_ready;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [LVL_W-1:0]         w_fifo_level;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [ADDR_W-1:0]        w_head_addr;
    logic [DATA_W-1:0]        w_head_data;
    logic                     w_head_in_range;
    logic                     w_start_ok;
    logic                     w_last_fill;

    // New writes are refused during a fill so nothing can land mid-fill.
    assign w_wr_ready      = !w_fifo_full && (r_state == ST_IDLE);
    assign w_push          = bus.wr_valid && w_wr_ready;
    assign w_pop           = (w_grant == G_WRITE);
    assign w_head_addr     = w_head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign w_head_data     = w_head[DATA_W-1:0];
    assign w_head_in_range = (32'(w_head_addr) < PIXELS);
    assign w_start_ok      = bus.clr_start && (r_state == ST_IDLE);
    assign w_last_fill     = (w_grant == G_CLEAR) && (r_clr_cnt == ADDR_W'(PIXELS - 32'd1));

    fb_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk       (clk_clk),
        .i_rst       (reset_reset),
        .i_push      (w_push),
        .i_push_data ({bus.wr_addr, bus.wr_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_level     (w_fifo_level)
    );

    // Slot owner for this cycle: scanout, then fill, then queued write.
    always_comb begin
        w_grant = G_IDLE;
        if (bus.rd_req) begin
            w_grant = G_READ;
        end else if (r_state == ST_CLEAR) begin
            w_grant = G_CLEAR;
        end else if (!w_fifo_empty) begin
            w_grant = G_WRITE;
        end else begin
            w_grant = G_IDLE;
        end
    end

    // Fill-engine FSM, fill counter and busy/done flags.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= ADDR_W'(0);
            r_clr_color <= DATA_W'(0);
            r_clr_busy  <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_clr_done <= w_last_fill;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_clr_color <= bus.clr_color;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_fifo_empty) begin
                        r_clr_cnt <= ADDR_W'(0);
                        r_state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // Only slots not stolen by scanout advance the fill.
                    if (w_last_fill) begin
                        r_state <= ST_IDLE;
                    end else if (w_grant == G_CLEAR) begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Busy stays up through the cycle in which the final fill write lands.
            if (w_start_ok) begin
                r_clr_busy <= 1'b1;
            end else if (r_clr_done) begin
                r_clr_busy <= 1'b0;
            end
        end
    end

    // Registered RAM port and scanout valid pipeline.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_mem_addr  <= ADDR_W'(0);
            r_mem_wdata <= DATA_W'(0);
            r_mem_we    <= 1'b0;
            r_rd_pipe   <= 2'b00;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], bus.rd_req};
            case (w_grant)
                G_READ: begin
                    r_mem_addr <= bus.rd_addr;
                    r_mem_we   <= 1'b0;
                end
                G_CLEAR: begin
                    r_mem_addr  <= r_clr_cnt;
                    r_mem_wdata <= r_clr_color;
                    r_mem_we    <= 1'b1;
                end
                G_WRITE: begin
                    // Off-screen entries consume the slot without touching RAM.
                    if (w_head_in_range) begin
                        r_mem_addr  <= w_head_addr;
                        r_mem_wdata <= w_head_data;
                        r_mem_we    <= 1'b1;
                    end else begin
                        r_mem_we <= 1'b0;
                    end
                end
                default: r_mem_we <= 1'b0;
            endcase
        end
    end

    assign bus.rd_data    = bus.mem_rdata;
    assign bus.rd_valid   = r_rd_pipe[1];
    assign bus.wr_ready   = w_wr_ready;
    assign bus.clr_busy   = r_clr_busy;
    assign bus.clr_done   = r_clr_done;
    assign bus.fifo_level = w_fifo_level;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
endmodule
